// File: rtl/leb128_decoder_pkg.sv
// Shared LEB128 decoder types, trap codes and limits.
// LEB128_64B_EN widens the accumulator to 64 bits and enables 10-byte decodes.
package leb128_pkg;

   typedef enum logic [1:0] {
      ACCUM,
      OUTPUT,
      ERROR
   } state_t;

   // Trap codes aliased into the core's trap space
   localparam logic [3:0] TRAP_NONE         = 4'd0;
   localparam logic [3:0] TRAP_LEB_OVERFLOW = 4'd9;
   localparam logic [3:0] TRAP_LEB_RANGE    = 4'd10;
   localparam logic [3:0] TRAP_NO_64B       = 4'd11;

   localparam int MAX_BYTES_32 = 5;
   localparam int MAX_BYTES_64 = 10;

`ifdef LEB128_64B_EN
   localparam int ACC_W = 64;
`else
   localparam int ACC_W = 32;
`endif

   function automatic logic [3:0] max_bytes(input logic w64);
      return w64 ? 4'(MAX_BYTES_64) : 4'(MAX_BYTES_32);
   endfunction

endpackage

// File: rtl/leb128_decoder_if.sv
// Byte-in / value-out handshake bundle for the LEB128 decoder.
interface leb128_decoder_if #(
   parameter int OUT_W = 64,
   parameter int LEN_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_byte;
   logic             is_signed;
   logic             is_64;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_value;
   logic [LEN_W-1:0] out_len;
   logic [3:0]       trap;

   modport master (
      output in_valid, in_byte, is_signed, is_64, out_ready,
      input  in_ready, out_valid, out_value, out_len, trap
   );

   modport slave (
      input  in_valid, in_byte, is_signed, is_64, out_ready,
      output in_ready, out_valid, out_value, out_len, trap
   );
endinterface

// File: rtl/leb128_decoder_final_check.sv
// Padding-bit check for the last permitted byte of a LEB128 number.
module leb128_final_check
   import leb128_pkg::*;
(
   input  logic [3:0] count,
   input  logic [6:0] data,
   input  logic       sgn,
   input  logic       w64,
   output logic       ok
);

   always_comb begin
      ok = 1'b1;
      if (count == max_bytes(w64) - 4'd1) begin
         unique case (1'b1)
            (!w64 && !sgn): ok = (data[6:4] == 3'b000);
            (!w64 &&  sgn): ok = (data[6:4] == {3{data[3]}});
            ( w64 && !sgn): ok = (data[6:1] == 6'b0);
            default:        ok = (data == 7'h00) || (data == 7'h7f);
         endcase
      end
   end

endmodule

// File: rtl/leb128_decoder.sv
// Streaming ULEB/SLEB128 immediate decoder, one byte per cycle.
// LEB128_64B_EN enables 64-bit targets; otherwise is_64 traps TRAP_NO_64B.
module leb128_decoder
   import leb128_pkg::*;
#(
   parameter int OUT_W = 64,
   parameter int LEN_W = 4
) (
   input logic             clk,
   input logic             reset,
   leb128_decoder_if.slave bus
);

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [3:0]       count;
   logic             sgn_q;
   logic             w64_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [OUT_W-1:0] out_value_q;
   logic [LEN_W-1:0] out_len_q;
   logic [3:0]       trap_q;

   logic        accept;
   logic        first;
   logic        sgn_c;
   logic        w64_c;
   logic        no64;
   logic        more;
   logic        range_ok;
   logic [3:0]  last_idx;
   logic [5:0]  sh;
   logic [6:0]  sh_n;
   logic [6:0]  tgt_w;
   logic [63:0] merged;
   logic [63:0] filled;
   logic [63:0] result;

   assign accept = bus.in_valid & in_ready_q;
   assign first  = (count == 4'd0);
   assign sgn_c  = first ? bus.is_signed : sgn_q;
   assign w64_c  = first ? bus.is_64 : w64_q;
`ifdef LEB128_64B_EN
   assign no64   = 1'b0;
`else
   assign no64   = first & bus.is_64;
`endif
   assign more     = bus.in_byte[7];
   assign last_idx = max_bytes(w64_c) - 4'd1;
   assign sh       = {2'b00, count} * 6'd7;
   assign sh_n     = {1'b0, sh} + 7'd7;
   assign tgt_w    = w64_c ? 7'd64 : 7'd32;
   assign merged   = 64'(acc) | (64'(bus.in_byte[6:0]) << sh);

   // Negative values: everything above the last payload bit becomes ones
   always_comb begin
      filled = merged;
      if (sgn_c && bus.in_byte[6] && (sh_n < tgt_w))
         filled = merged | ~((64'd1 << sh_n) - 64'd1);
   end

   always_comb begin
      result = filled;
      if (!w64_c)
         result = sgn_c ? {{32{filled[31]}}, filled[31:0]}
                        : {32'b0, filled[31:0]};
   end

   leb128_final_check u_chk (
      .count (count),
      .data  (bus.in_byte[6:0]),
      .sgn   (sgn_c),
      .w64   (w64_c),
      .ok    (range_ok)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ACCUM;
         acc         <= '0;
         count       <= '0;
         sgn_q       <= 1'b0;
         w64_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_value_q <= '0;
         out_len_q   <= '0;
         trap_q      <= TRAP_NONE;
      end else begin
         unique case (state)
            ACCUM: begin
               in_ready_q <= 1'b1;
               if (accept) begin
                  if (first) begin
                     sgn_q <= bus.is_signed;
                     w64_q <= bus.is_64;
                  end
                  if (no64) begin
                     state      <= ERROR;
                     trap_q     <= TRAP_NO_64B;
                     in_ready_q <= 1'b0;
                  end else if (more && count == last_idx) begin
                     state      <= ERROR;
                     trap_q     <= TRAP_LEB_OVERFLOW;
                     in_ready_q <= 1'b0;
                  end else if (more) begin
                     acc   <= merged[ACC_W-1:0];
                     count <= count + 4'd1;
                  end else if (!range_ok) begin
                     state      <= ERROR;
                     trap_q     <= TRAP_LEB_RANGE;
                     in_ready_q <= 1'b0;
                  end else begin
                     state       <= OUTPUT;
                     acc         <= filled[ACC_W-1:0];
                     count       <= count + 4'd1;
                     out_valid_q <= 1'b1;
                     out_value_q <= result[OUT_W-1:0];
                     out_len_q   <= LEN_W'(count + 4'd1);
                     in_ready_q  <= 1'b0;
                  end
               end
            end
            OUTPUT: begin
               if (bus.out_ready) begin
                  state       <= ACCUM;
                  acc         <= '0;
                  count       <= '0;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            ERROR: begin
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
            end
            default: state <= ERROR;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_value = out_value_q;
   assign bus.out_len   = out_len_q;
   assign bus.trap      = trap_q;

endmodule
